// File: rtl/ap_prefix_builder.sv
// Active-prefix builder: appends 4-bit symbols, looks the prefix up in codebook_b3, emits codewords.
// Optional macro AP_FAST_PATH_EN lets a new symbol be accepted on the same edge as the codeword handshake.
module ap_prefix_builder #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int PREFIX_MAX          = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sym_valid_i,
    output logic                           sym_ready_o,
    input  logic [3:0]                     sym_data_i,
    input  logic                           sym_last_i,
    output logic [5:0]                     ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
    input  logic                           encode_match_i,
    input  logic [5:0]                     encode_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   encode_data_i,
    output logic                           cw_valid_o,
    input  logic                           cw_ready_i,
    output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
    output logic [5:0]                     cw_length_o,
    output logic                           cw_raw_o,
    output logic                           cw_last_o,
    output logic                           err_o
);

    typedef enum logic [1:0] {COLLECT, CHECK, EMIT} state_t;

    state_t                           state_q;
    logic [5:0]                       ap_cnt_q;
    logic [CODEBOOK_LENGTH_MAX-1:0]   ap_data_q;
    logic                             last_q;
    logic                             cw_valid_q;
    logic [ENCODE_DATALENGTH-1:0]     cw_data_q;
    logic [5:0]                       cw_length_q;
    logic                             cw_raw_q;
    logic                             cw_last_q;
    logic                             err_q;

    logic [CODEBOOK_LENGTH_MAX-1:0]   ap_shift_d;
    logic [5:0]                       raw_len_d;
    logic [ENCODE_DATALENGTH-1:0]     raw_data_d;
    logic                             flush_d;

    // Keeps only the low len bits so every codeword is zero above its length.
    function automatic logic [ENCODE_DATALENGTH-1:0] mask_len(
        input logic [ENCODE_DATALENGTH-1:0] v,
        input logic [5:0]                   len
    );
        logic [ENCODE_DATALENGTH-1:0] m;
        for (int i = 0; i < ENCODE_DATALENGTH; i++) begin
            m[i] = v[i] & (i < int'(len));
        end
        return m;
    endfunction

    assign ap_shift_d = {ap_data_q[CODEBOOK_LENGTH_MAX-5:0], sym_data_i};
    assign raw_len_d  = {ap_cnt_q[3:0], 2'b00};
    assign raw_data_d = mask_len(ap_data_q[ENCODE_DATALENGTH-1:0], raw_len_d);
    assign flush_d    = last_q || (ap_cnt_q == 6'(PREFIX_MAX));

`ifdef AP_FAST_PATH_EN
    assign sym_ready_o = !rst_i && ((state_q == COLLECT) || ((state_q == EMIT) && cw_ready_i));
`else
    assign sym_ready_o = !rst_i && (state_q == COLLECT);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            ap_cnt_q    <= '0;
            ap_data_q   <= '0;
            last_q      <= 1'b0;
            cw_valid_q  <= 1'b0;
            cw_data_q   <= '0;
            cw_length_q <= '0;
            cw_raw_q    <= 1'b0;
            cw_last_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (sym_valid_i) begin
                        ap_data_q <= ap_shift_d;
                        ap_cnt_q  <= ap_cnt_q + 6'd1;
                        last_q    <= sym_last_i;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (encode_match_i) begin
                        cw_data_q   <= mask_len(encode_data_i, encode_length_i);
                        cw_length_q <= encode_length_i;
                        cw_raw_q    <= 1'b0;
                        cw_last_q   <= last_q;
                        cw_valid_q  <= 1'b1;
                        ap_cnt_q    <= '0;
                        ap_data_q   <= '0;
                        state_q     <= EMIT;
                    end else if (flush_d) begin
                        // A full prefix with no match is an overflow; a segment end is not.
                        if (!last_q) begin
                            err_q <= 1'b1;
                        end
                        cw_data_q   <= raw_data_d;
                        cw_length_q <= raw_len_d;
                        cw_raw_q    <= 1'b1;
                        cw_last_q   <= last_q;
                        cw_valid_q  <= 1'b1;
                        ap_cnt_q    <= '0;
                        ap_data_q   <= '0;
                        state_q     <= EMIT;
                    end else begin
                        state_q <= COLLECT;
                    end
                end
                EMIT: begin
                    if (cw_ready_i) begin
                        cw_valid_q <= 1'b0;
                        cw_last_q  <= 1'b0;
                        state_q    <= COLLECT;
`ifdef AP_FAST_PATH_EN
                        if (sym_valid_i) begin
                            ap_data_q <= ap_shift_d;
                            ap_cnt_q  <= ap_cnt_q + 6'd1;
                            last_q    <= sym_last_i;
                            state_q   <= CHECK;
                        end
`endif
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign ap_cnt_o    = ap_cnt_q;
    assign ap_data_o   = ap_data_q;
    assign cw_valid_o  = cw_valid_q;
    assign cw_data_o   = cw_data_q;
    assign cw_length_o = cw_length_q;
    assign cw_raw_o    = cw_raw_q;
    assign cw_last_o   = cw_last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ap_prefix_builder.sv
// Directed bench for ap_prefix_builder with a small stand-in codebook_b3 table.
module tb_ap_prefix_builder;

    logic        clk;
    logic        rst;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_data;
    logic        sym_last;
    logic [5:0]  ap_cnt;
    logic [63:0] ap_data;
    logic        enc_match;
    logic [5:0]  enc_len;
    logic [20:0] enc_data;
    logic        cw_valid;
    logic        cw_ready;
    logic [20:0] cw_data;
    logic [5:0]  cw_length;
    logic        cw_raw;
    logic        cw_last;
    logic        err;

    int tests = 0;
    int fails = 0;

    ap_prefix_builder #(
        .CODEBOOK_LENGTH_MAX(64),
        .ENCODE_DATALENGTH  (21),
        .PREFIX_MAX         (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sym_valid_i    (sym_valid),
        .sym_ready_o    (sym_ready),
        .sym_data_i     (sym_data),
        .sym_last_i     (sym_last),
        .ap_cnt_o       (ap_cnt),
        .ap_data_o      (ap_data),
        .encode_match_i (enc_match),
        .encode_length_i(enc_len),
        .encode_data_i  (enc_data),
        .cw_valid_o     (cw_valid),
        .cw_ready_i     (cw_ready),
        .cw_data_o      (cw_data),
        .cw_length_o    (cw_length),
        .cw_raw_o       (cw_raw),
        .cw_last_o      (cw_last),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codebook entries: {1} -> 00, {0,2} -> 0101, {0,0,1,0} -> 1101001.
    always_comb begin
        enc_match = 1'b0;
        enc_len   = 6'd0;
        enc_data  = 21'd0;
        if (ap_cnt == 6'd1 && ap_data[3:0] == 4'h1) begin
            enc_match = 1'b1; enc_len = 6'd2; enc_data = 21'b00;
        end else if (ap_cnt == 6'd2 && ap_data[7:0] == 8'h02) begin
            enc_match = 1'b1; enc_len = 6'd4; enc_data = 21'b0101;
        end else if (ap_cnt == 6'd4 && ap_data[15:0] == 16'h0010) begin
            enc_match = 1'b1; enc_len = 6'd7; enc_data = 21'b1101001;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic last);
        int n = 0;
        while (!sym_ready && n < 20) begin
            step();
            n++;
        end
        if (!sym_ready) chk("sym_ready_timeout", 64'(sym_ready), 64'd1);
        sym_valid = 1'b1;
        sym_data  = d;
        sym_last  = last;
        step();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sym_valid = 1'b0; sym_data = 4'h0; sym_last = 1'b0; cw_ready = 1'b1;
        step(); step();
        chk("rst_sym_ready", 64'(sym_ready), 64'd0);
        chk("rst_ap_cnt",    64'(ap_cnt),    64'd0);
        chk("rst_ap_data",   ap_data,        64'd0);
        chk("rst_cw_valid",  64'(cw_valid),  64'd0);
        chk("rst_cw_data",   64'(cw_data),   64'd0);
        chk("rst_err",       64'(err),       64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(sym_ready), 64'd1);

        // Single-symbol match
        send(4'h1, 1'b0);
        chk("t1_ap_cnt",   64'(ap_cnt),   64'd1);
        chk("t1_ap_data",  ap_data,       64'h1);
        chk("t1_check_vld", 64'(cw_valid), 64'd0);
        step();
        chk("t1_cw_valid", 64'(cw_valid),  64'd1);
        chk("t1_cw_data",  64'(cw_data),   64'b00);
        chk("t1_cw_len",   64'(cw_length), 64'd2);
        chk("t1_cw_raw",   64'(cw_raw),    64'd0);
        chk("t1_cw_last",  64'(cw_last),   64'd0);
        chk("t1_ap_clear", 64'(ap_cnt),    64'd0);
        step();
        chk("t1_vld_drop", 64'(cw_valid),  64'd0);

        // Two-symbol match
        send(4'h0, 1'b0);
        step();
        chk("t2_no_out",   64'(cw_valid),  64'd0);
        chk("t2_cnt1",     64'(ap_cnt),    64'd1);
        send(4'h2, 1'b0);
        chk("t2_ap_data",  ap_data,        64'h02);
        step();
        chk("t2_cw_valid", 64'(cw_valid),  64'd1);
        chk("t2_cw_data",  64'(cw_data),   64'b0101);
        chk("t2_cw_len",   64'(cw_length), 64'd4);
        chk("t2_cnt0",     64'(ap_cnt),    64'd0);
        step();

        // Four-symbol match
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h1, 1'b0);
        send(4'h0, 1'b0);
        chk("t3_ap_data",  ap_data,        64'h0010);
        step();
        chk("t3_cw_valid", 64'(cw_valid),  64'd1);
        chk("t3_cw_data",  64'(cw_data),   64'b1101001);
        chk("t3_cw_len",   64'(cw_length), 64'd7);
        chk("t3_err",      64'(err),       64'd0);
        step();

        // Overflow: four unmatched symbols
        send(4'h7, 1'b0);
        send(4'h7, 1'b0);
        send(4'h7, 1'b0);
        send(4'h7, 1'b0);
        step();
        chk("t4_err",      64'(err),       64'd1);
        chk("t4_cw_valid", 64'(cw_valid),  64'd1);
        chk("t4_cw_data",  64'(cw_data),   64'h7777);
        chk("t4_cw_len",   64'(cw_length), 64'd16);
        chk("t4_cw_raw",   64'(cw_raw),    64'd1);
        chk("t4_cw_last",  64'(cw_last),   64'd0);
        step();

        // Last flag forces raw flush
        send(4'h2, 1'b1);
        step();
        chk("t5_cw_valid", 64'(cw_valid),  64'd1);
        chk("t5_cw_data",  64'(cw_data),   64'h2);
        chk("t5_cw_len",   64'(cw_length), 64'd4);
        chk("t5_cw_raw",   64'(cw_raw),    64'd1);
        chk("t5_cw_last",  64'(cw_last),   64'd1);
        chk("t5_err_stick", 64'(err),      64'd1);
        step();
        chk("t5_last_clr", 64'(cw_last),   64'd0);
        chk("t5_vld_clr",  64'(cw_valid),  64'd0);

        // Match with last: codebook word, last set, no extra flush
        send(4'h1, 1'b1);
        step();
        chk("t6_cw_data",  64'(cw_data),   64'b00);
        chk("t6_cw_len",   64'(cw_length), 64'd2);
        chk("t6_cw_raw",   64'(cw_raw),    64'd0);
        chk("t6_cw_last",  64'(cw_last),   64'd1);
        step();
        step();
        chk("t6_no_flush", 64'(cw_valid),  64'd0);

        // Backpressure
        cw_ready = 1'b0;
        send(4'h0, 1'b0);
        send(4'h2, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(cw_valid),  64'd1);
            chk("bp_data",  64'(cw_data),   64'b0101);
            chk("bp_len",   64'(cw_length), 64'd4);
            chk("bp_ready", 64'(sym_ready), 64'd0);
            step();
        end
        cw_ready = 1'b1;
        step();
        chk("bp_release", 64'(cw_valid), 64'd0);

        // Reset during EMIT
        cw_ready = 1'b0;
        send(4'h1, 1'b0);
        step();
        chk("rm_pre_valid", 64'(cw_valid), 64'd1);
        rst = 1'b1;
        #2;
        chk("rm_valid",  64'(cw_valid),  64'd0);
        chk("rm_data",   64'(cw_data),   64'd0);
        chk("rm_len",    64'(cw_length), 64'd0);
        chk("rm_err",    64'(err),       64'd0);
        chk("rm_ready",  64'(sym_ready), 64'd0);
        step();
        rst = 1'b0;
        cw_ready = 1'b1;
        step();
        step();
        chk("rm_no_cw",  64'(cw_valid),  64'd0);
        chk("rm_cnt",    64'(ap_cnt),    64'd0);
        send(4'h1, 1'b0);
        step();
        chk("rm_alive",  64'(cw_valid),  64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ap_prefix_builder.md
# ap_prefix_builder

Active-prefix builder for the low-entropy path of the hybrid entropy coder. It accepts one 4-bit low-entropy symbol at a time, where 'hF is the escape symbol X. Each symbol is appended to the active prefix, and the registered prefix is presented to the combinational `codebook_b3` lookup. When the lookup reports a match, the block emits the returned codeword over a valid/ready handshake to the downstream bit packer and clears the prefix.

## Interface
Parameters:
- `CODEBOOK_LENGTH_MAX`, 64, width of `ap_data_o`; must match `codebook_b3`.
- `ENCODE_DATALENGTH`, 21, width of codeword data; must match `codebook_b3`.
- `PREFIX_MAX`, 4, longest legal prefix in symbols; must satisfy 4·`PREFIX_MAX` ≤ `ENCODE_DATALENGTH`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sym_valid_i` in 1: input symbol valid.
- `sym_ready_o` out 1: block can accept a symbol.
- `sym_data_i` in 4: symbol value 'h0–'hF.
- `sym_last_i` in 1: last symbol of the segment; forces a flush.
- `ap_cnt_o` out 6: registered prefix length, wired to `codebook_b3.ap_cnt_i`.
- `ap_data_o` out `CODEBOOK_LENGTH_MAX`: registered prefix, newest symbol in bits [3:0], wired to `codebook_b3.ap_data_i`.
- `encode_match_i` in 1: match flag from the codebook.
- `encode_length_i` in 6: codeword length from the codebook.
- `encode_data_i` in `ENCODE_DATALENGTH`: codeword from the codebook, right-justified.
- `cw_valid_o` out 1: codeword valid.
- `cw_ready_i` in 1: downstream accepts the codeword.
- `cw_data_o` out `ENCODE_DATALENGTH`: codeword, right-justified, zero above `cw_length_o`.
- `cw_length_o` out 6: codeword length in bits.
- `cw_raw_o` out 1: codeword is a raw flush (unmatched prefix) rather than a codebook entry.
- `cw_last_o` out 1: final codeword of the segment.
- `err_o` out 1: sticky overflow flag; cleared only by reset.

## Operation
- FSM states: COLLECT, CHECK, EMIT.
- **Reset values:**
  - State = COLLECT.
  - `ap_cnt_o` = 0 and `ap_data_o` = 0.
  - All `cw_*` outputs = 0.
  - `err_o` = 0.
  - `sym_ready_o` = 0 while `rst_i` is high.
- **COLLECT:**
  - `sym_ready_o` = 1.
  - On `sym_valid_i` & `sym_ready_o`: `ap_data` ← {`ap_data`[N-5:0], `sym_data_i`}, `ap_cnt` ← `ap_cnt`+1, latch `sym_last_i`, then go to CHECK.
- **CHECK** (codebook settles on the registered prefix; `sym_ready_o` = 0). Cases are evaluated in this order:
  - `encode_match_i` = 1: load `cw_data` and `cw_length` from the codebook, `cw_raw` = 0, clear the prefix, go to EMIT.
  - No match, latched last = 1: raw flush. `cw_data` = `ap_data`[4·`ap_cnt`−1:0], `cw_length` = 4·`ap_cnt`, `cw_raw` = 1. Clear the prefix, go to EMIT.
  - No match, `ap_cnt` = `PREFIX_MAX`: set `err_o`, then perform the raw flush exactly as above, go to EMIT.
  - Otherwise: go to COLLECT with the prefix retained.
- `cw_last_o` = latched last flag, valid in EMIT.
- **EMIT:**
  - `cw_valid_o` = 1; all `cw_*` outputs are held stable until `cw_ready_i` is high.
  - On handshake: `cw_valid_o` deasserts next cycle and the state returns to COLLECT.
  - `cw_last_o` clears on the handshake.
- A match and a last flag in the same CHECK cycle produce a codebook codeword with `cw_last_o` = 1 and no separate flush word.
- Reset mid-operation: the prefix, the pending codeword and `err_o` are discarded; no partial handshake is completed.

## Timing
- Symbol accepted at edge N: `ap_*_o` updated after edge N, CHECK occupies cycle N+1, `cw_valid_o` is high after edge N+1.
- Latency from symbol to codeword = 2 cycles when `cw_ready_i` is held high.
- Non-matching symbol: COLLECT→CHECK→COLLECT, so one symbol per 2 cycles.
- Matching symbol with `cw_ready_i` = 1: 3 cycles per codeword (2 with the fast path).
- `sym_ready_o` is a function of state (and `cw_ready_i` with the fast path) only; it never depends on `sym_valid_i`.

## Configuration
- `AP_FAST_PATH_EN` defined:
  - In EMIT, `sym_ready_o` = `cw_ready_i`.
  - A symbol may be accepted in the same cycle as the codeword handshake; it goes directly to CHECK with `ap_cnt` = 1.
- `AP_FAST_PATH_EN` undefined: `sym_ready_o` = 1 only in COLLECT.
- In both cases, codeword content and ordering are identical.

## Test plan
- Symbol 'h1, `cw_ready_i` = 1 → codeword 'b00, length 2, `cw_raw_o` = 0, `cw_valid_o` high 2 cycles after acceptance.
- Symbols 'h0, 'h2 → no output after 'h0 (`ap_cnt_o` = 1); after 'h2, codeword 'b0101, length 4; `ap_cnt_o` then returns to 0.
- Symbols 'h0, 'h0, 'h1, 'h0 → single codeword 'b1101001, length 7.
- Symbols 'h7 ×4 → `err_o` = 1, codeword 'h7777, length 16, `cw_raw_o` = 1.
- Symbol 'h2 with `sym_last_i` = 1 → raw codeword 'h2, length 4, `cw_last_o` = 1.
- Backpressure and reset:
  - With `cw_ready_i` = 0 for 5 cycles after a match: `cw_*` outputs stay stable and `sym_ready_o` = 0.
  - `rst_i` pulsed during EMIT → all outputs 0 and no codeword is delivered.
